// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer, sync flush and stall.
// Optional stall statistics counter enabled by defining PIPE_REG_SKID_STATS_EN.
module pipe_reg_skid #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_SKID_STATS_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             in_fire, out_fire;

  // Ready/valid come from registered state only; rst_n gating holds in_ready low during reset.
  assign in_ready  = rst_n & en & (state != ST_FULL);
  assign out_valid = en & (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = RESET_VAL;
      skid_nxt  = RESET_VAL;
    end else begin
      // Both fires are already gated by en, so a stall simply falls through to "hold".
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_nxt  = in_data;
            state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          case ({in_fire, out_fire})
            2'b11: main_nxt = in_data;
            2'b01: state_nxt = ST_EMPTY;
            2'b10: begin
              skid_nxt  = in_data;
              state_nxt = ST_FULL;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (out_fire) begin
            main_nxt  = skid_q;
            state_nxt = ST_BUSY;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the data registers are reset too, because RESET_VAL is visible on out_data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state  <= ST_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

`ifdef PIPE_REG_SKID_STATS_EN
  logic [31:0] stall_q;

  // Counts downstream back-pressure cycles; saturates and deliberately ignores flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Randomised plus directed bench for pipe_reg_skid: a queue-based reference model and a
// scoreboard monitor that checks every delivered word. Covers stall_cnt when PIPE_REG_SKID_STATS_EN is set.
module tb_pipe_reg_skid;

  localparam int unsigned W      = 32;
  localparam logic [W-1:0] RST_V = 32'hDEAD_BEEF;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_REG_SKID_STATS_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  st_model;
`endif

  pipe_reg_skid #(.WIDTH(W), .RESET_VAL(RST_V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stage is a FIFO of at most two words; out_data shows the oldest held
  // word, or the last word delivered (RST_V after reset/flush) when nothing is held.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_pop;
  int           cur_occ;
  int           n_pass;
  int           n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] exp_main();
    return (exp_q.size() > 0) ? exp_q[0] : last_pop;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    last_pop = RST_V;
    cur_occ  = 0;
  endtask

  // One clock cycle: drive inputs after the edge, check the outputs against the model,
  // and push the word into the scoreboard if the model says the stage accepts it.
  task automatic cycle(input logic e, input logic f, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
    int occ;
    @(posedge clk);
    #1;
    en        = e;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    occ = exp_q.size();
    check("in_ready", 32'(in_ready), 32'(e && (occ < 2)));
    check("out_valid", 32'(out_valid), 32'(e && (occ > 0)));
    check("out_data", out_data, exp_main());
`ifdef PIPE_REG_SKID_STATS_EN
    check("stall_cnt", stall_cnt, st_model);
`endif
    cur_occ = occ;
    if (!f && e && iv && (occ < 2)) exp_q.push_back(d);
  endtask

  // Scoreboard monitor: mid-cycle, whatever the DUT presents and downstream takes is compared.
  always @(negedge clk) begin
    logic [W-1:0] w;
    if (rst_n) begin
`ifdef PIPE_REG_SKID_STATS_EN
      if (en && (cur_occ > 0) && !out_ready && (st_model != 32'hFFFF_FFFF)) st_model++;
`endif
      if (flush) begin
        exp_q.delete();
        last_pop = RST_V;
      end else if (out_valid && out_ready) begin
        check("deliver_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("deliver_data", out_data, w);
          last_pop = w;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PIPE_REG_SKID_STATS_EN
    logic [31:0] base;
`endif
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
`ifdef PIPE_REG_SKID_STATS_EN
    st_model = '0;
`endif
    en = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", out_data, RST_V);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Streaming: one word per cycle, never reaches two held words.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b1, W'(i), 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Backpressure then stall while full, then resume: A then B.
    cycle(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hC, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'hD, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Flush while full with a word offered, then flush killing an accepted word.
    cycle(1'b1, 1'b0, 1'b1, 32'hA1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hB1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'hC1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'hE1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'hF1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

`ifdef PIPE_REG_SKID_STATS_EN
    // Five back-pressured cycles with one stalled, then flush: counter moves by exactly 4.
    base = st_model;
    cycle(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b1);
    check("stats_four", stall_cnt, base + 32'd4);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("stats_after_flush", stall_cnt, base + 32'd4);
`endif

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 6));
    end

    // Asynchronous reset mid-stream while holding two words.
    cycle(1'b1, 1'b0, 1'b1, 32'h1111, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h2222, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h3333, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    check("async_out_data", out_data, RST_V);
    model_clear();
`ifdef PIPE_REG_SKID_STATS_EN
    st_model = '0;
    check("async_stall_cnt", stall_cnt, 32'd0);
`endif
    en        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 32'h77, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
